// File: rtl/dstack_ctrl.sv
// dstack_ctrl: data-stack front end holding T in a register and driving the N-stack memory
module dstack_ctrl #(
    parameter int SADDR_WIDTH = 8,
    parameter int WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_valid,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     din,
    output logic                 op_ready,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     tos,
    output logic [WIDTH-1:0]     nos,
    output logic [SADDR_WIDTH:0] depth,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf,
    output logic                 unf,
    input  logic                 wait_state,
    output logic [WIDTH-1:0]     s_d,
    output logic                 s_dec,
    output logic                 s_change,
    output logic                 s_update,
    output logic                 s_reset,
    input  logic [WIDTH-1:0]     s_q
);
    localparam logic [2:0] OP_PUSH = 3'd1, OP_DROP = 3'd2, OP_DUP = 3'd3, OP_SWAP = 3'd4,
                           OP_OVER = 3'd5, OP_REPL = 3'd6, OP_NIP  = 3'd7;
    localparam logic [SADDR_WIDTH:0] DEPTH_MAX = {1'b1, {SADDR_WIDTH{1'b0}}};
    localparam logic [SADDR_WIDTH:0] ONE       = 1;

    typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     tos_nx;
    logic [SADDR_WIDTH:0] depth_nx;
    logic                 ovf_nx, unf_nx;
    logic                 acc, grows, shrinks, ovf_c, unf_c, go;

    assign op_ready = (state == RUN) && !wait_state;
    assign s_reset  = (state == INIT);
    assign empty    = (depth == '0);
    assign full     = (depth == DEPTH_MAX);
    assign nos      = s_q;
    assign s_d      = tos;

    // Decode the accepted op into legality and the combinational stack strobes
    always_comb begin
        acc      = op_valid && op_ready;
        grows    = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
        shrinks  = (op == OP_DROP) || (op == OP_NIP);
        ovf_c    = grows && full;
        unf_c    = !ovf_c && ((((op == OP_DUP) || (op == OP_REPL) || (op == OP_DROP)) && empty) ||
                   (((op == OP_SWAP) || (op == OP_OVER) || (op == OP_NIP)) && (depth[SADDR_WIDTH:1] == '0)));
        go       = acc && !ovf_c && !unf_c;
        s_change = go && (grows || shrinks);
        s_dec    = go && shrinks;
        s_update = go && (grows || (op == OP_SWAP));
    end

    // Next state, T, depth and sticky flags
    always_comb begin
        state_nx = state;
        tos_nx   = tos;
        depth_nx = depth;
        ovf_nx   = ovf;
        unf_nx   = unf;
        case (state)
            INIT: state_nx = RUN;
            RUN: begin
                if (acc && (ovf_c || unf_c)) begin
                    state_nx = FAULT;
                    ovf_nx   = ovf | ovf_c;
                    unf_nx   = unf | unf_c;
                end else if (go) begin
                    depth_nx = grows ? depth + ONE : shrinks ? depth - ONE : depth;
                    case (op)
                        OP_PUSH, OP_REPL: tos_nx = din;
                        OP_OVER, OP_SWAP: tos_nx = s_q;
                        OP_DROP:          tos_nx = (depth == ONE) ? '0 : s_q;
                        default:          tos_nx = tos;
                    endcase
                end
            end
            FAULT: begin
                if (err_clr) begin
                    state_nx = INIT;
                    tos_nx   = '0;
                    depth_nx = '0;
                    ovf_nx   = 1'b0;
                    unf_nx   = 1'b0;
                end
            end
            default: state_nx = INIT;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            tos   <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_nx;
            tos   <= tos_nx;
            depth <= depth_nx;
            ovf   <= ovf_nx;
            unf   <= unf_nx;
        end
    end
endmodule
